// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default widths, fetch-stage state encoding and the
// opcode constants the control FSM decodes from IR.
package cpu_pkg;

    localparam int ADDR_W_DEF  = 8;
    localparam int INSTR_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        PF   = 2'd2
    } fetch_state_t;

    localparam logic [3:0] OP_NOOP  = 4'd0;
    localparam logic [3:0] OP_STORE = 4'd1;
    localparam logic [3:0] OP_LOAD  = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_HALT  = 4'd5;

    // Opcode lives in the top nibble of an instruction word.
    function automatic logic [3:0] opcode_of(input logic [INSTR_W_DEF-1:0] instr);
        return instr[INSTR_W_DEF-1 -: 4];
    endfunction

endpackage

// File: rtl/pc_counter.sv
// Program counter: clear has priority over increment, increment wraps modulo
// 2^ADDR_W.
module pc_counter
    import cpu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              clr_i,
    input  logic              up_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (clr_i) begin
            pc_d = '0;
        end else if (up_i) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns PC and IR, runs the request/ack handshake to
// instruction memory. Optional one-entry prefetch buffer: INSTR_FETCH_PREFETCH_EN.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic               PC_Clr,
    input  logic               PC_Up,
    input  logic               IR_Id,
    output logic               IM_req,
    output logic [ADDR_W-1:0]  IM_addr,
    input  logic               IM_ack,
    input  logic [INSTR_W-1:0] IM_data,
    output logic [INSTR_W-1:0] IR,
    output logic [ADDR_W-1:0]  PC,
    output logic               IR_valid,
    output logic               Fetch_busy
);

    fetch_state_t       state_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [INSTR_W-1:0] ir_q;
    logic               ir_valid_q;
    logic               flush_q;

`ifdef INSTR_FETCH_PREFETCH_EN
    logic [ADDR_W-1:0]  pf_addr_q;
    logic [INSTR_W-1:0] pf_data_q;
    logic               pf_valid_q;
    logic               pend_q;
    logic [ADDR_W-1:0]  dem_addr_q;
    logic               pf_hit;
    logic [ADDR_W-1:0]  want_addr;

    assign pf_hit    = pf_valid_q && (pf_addr_q == PC) && !PC_Clr;
    // A demand raised in the ack cycle itself still wants the current PC.
    assign want_addr = pend_q ? dem_addr_q : PC;
`endif

    pc_counter #(.ADDR_W(ADDR_W)) u_pc (
        .clk   (clk),
        .Reset (Reset),
        .clr_i (PC_Clr),
        .up_i  (PC_Up),
        .pc_o  (PC)
    );

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            flush_q    <= 1'b0;
`ifdef INSTR_FETCH_PREFETCH_EN
            pf_addr_q  <= '0;
            pf_data_q  <= '0;
            pf_valid_q <= 1'b0;
            pend_q     <= 1'b0;
            dem_addr_q <= '0;
`endif
        end else begin
            if (PC_Clr) begin
                ir_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (IR_Id) begin
`ifdef INSTR_FETCH_PREFETCH_EN
                        if (pf_hit) begin
                            ir_q       <= pf_data_q;
                            ir_valid_q <= 1'b1;
                            pf_valid_q <= 1'b0;
                        end else begin
                            addr_q  <= PC;
                            flush_q <= PC_Clr;
                            state_q <= REQ;
                        end
`else
                        addr_q  <= PC;
                        flush_q <= PC_Clr;
                        state_q <= REQ;
`endif
                    end
`ifdef INSTR_FETCH_PREFETCH_EN
                    else if (ir_valid_q && !pf_valid_q && !PC_Clr) begin
                        addr_q  <= PC;
                        flush_q <= 1'b0;
                        pend_q  <= 1'b0;
                        state_q <= PF;
                    end
`endif
                end
                REQ: begin
                    if (PC_Clr) begin
                        flush_q <= 1'b1;
                    end
                    if (IM_ack) begin
                        // Flushed data is dropped; the request itself is never withdrawn.
                        if (!(flush_q || PC_Clr)) begin
                            ir_q       <= IM_data;
                            ir_valid_q <= 1'b1;
                        end else begin
                            ir_valid_q <= 1'b0;
                        end
                        flush_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
`ifdef INSTR_FETCH_PREFETCH_EN
                PF: begin
                    if (PC_Clr) begin
                        flush_q <= 1'b1;
                        pend_q  <= 1'b0;
                    end else if (IR_Id && !pend_q) begin
                        pend_q     <= 1'b1;
                        dem_addr_q <= PC;
                    end
                    if (IM_ack) begin
                        state_q <= IDLE;
                        flush_q <= 1'b0;
                        pend_q  <= 1'b0;
                        if (!(flush_q || PC_Clr)) begin
                            if (pend_q || IR_Id) begin
                                if (addr_q == want_addr) begin
                                    ir_q       <= IM_data;
                                    ir_valid_q <= 1'b1;
                                end else begin
                                    addr_q  <= want_addr;
                                    state_q <= REQ;
                                end
                            end else begin
                                pf_addr_q  <= addr_q;
                                pf_data_q  <= IM_data;
                                pf_valid_q <= 1'b1;
                            end
                        end
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
`ifdef INSTR_FETCH_PREFETCH_EN
            if (PC_Clr) begin
                pf_valid_q <= 1'b0;
            end
`endif
        end
    end

    assign IM_req   = (state_q != IDLE);
    assign IM_addr  = addr_q;
    assign IR       = ir_q;
    assign IR_valid = ir_valid_q;

`ifdef INSTR_FETCH_PREFETCH_EN
    assign Fetch_busy = (state_q == REQ) || ((state_q == PF) && pend_q) ||
                        (IR_Id && (state_q != IDLE));
`else
    assign Fetch_busy = (state_q == REQ) || (IR_Id && (state_q != IDLE));
`endif

endmodule
